// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns the PS/2 set-2 byte stream into single key events. E0 (extended)
//   and F0 (break) prefixes are folded into flags on the following code byte;
//   keyboard status/response bytes are dropped. Events are queued in a
//   first-word-fall-through FIFO for the host.
//
// Ports
//   clk        : 16 MHz system clock, rising edge
//   reset      : synchronous, active-high
//   rx_data    : received byte, qualified by rx_valid
//   rx_valid   : one-cycle strobe per byte
//   rx_err     : one-cycle strobe on receiver framing/parity error
//   evt_rd     : pop head event (ignored when empty)
//   evt_code   : head scan code (0 when empty)
//   evt_ext    : head had E0 prefix (0 when empty)
//   evt_break  : head is a release (0 when empty)
//   evt_empty  : FIFO empty
//   evt_count  : events held, 0..FIFO_DEPTH
//   overflow   : sticky, an event was lost to a full FIFO
//   seq_err    : one-cycle pulse when a prefix sequence is aborted
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FIFO_AW        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               rx_err,
  input  logic               evt_rd,
  output logic [7:0]         evt_code,
  output logic               evt_ext,
  output logic               evt_break,
  output logic               evt_empty,
  output logic [FIFO_AW:0]   evt_count,
  output logic               overflow,
  output logic               seq_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GOT_E0,
    S_GOT_F0,
    S_GOT_E0F0
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TW-1:0]     r_tmo;
  logic              r_seq_err;
  logic              w_seq_err;
  logic              w_timeout;
  logic              w_is_e0;
  logic              w_is_f0;
  logic              w_discard;
  logic              w_push;
  logic              w_push_ext;
  logic              w_push_brk;

  logic [9:0]        r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]  r_count;
  logic              r_overflow;
  logic              w_empty;
  logic              w_full;
  logic              w_rd;
  logic              w_wr;
  logic [9:0]        w_head;

  assign w_is_e0   = (rx_data == 8'hE0);
  assign w_is_f0   = (rx_data == 8'hF0);
  assign w_timeout = (r_state != S_IDLE) && (r_tmo == TMO_LAST);

  always_comb begin
    w_discard = 1'b0;
    case (rx_data)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1: w_discard = 1'b1;
      default:                                          w_discard = 1'b0;
    endcase
  end

  // Priority: rx_err over a coincident byte, a byte over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_ext  = 1'b0;
    w_push_brk  = 1'b0;
    w_seq_err   = 1'b0;
    if (rx_err) begin
      w_state_nxt = S_IDLE;
      w_seq_err   = (r_state != S_IDLE);
    end else if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_e0)        w_state_nxt = S_GOT_E0;
          else if (w_is_f0)   w_state_nxt = S_GOT_F0;
          else if (!w_discard) w_push     = 1'b1;
        end
        S_GOT_E0: begin
          if (w_is_f0)       w_state_nxt = S_GOT_E0F0;
          else if (!w_is_e0) begin
            w_push      = 1'b1;
            w_push_ext  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_GOT_F0: begin
          w_state_nxt = S_IDLE;
          if (w_is_e0 || w_is_f0) w_seq_err = 1'b1;
          else begin
            w_push     = 1'b1;
            w_push_brk = 1'b1;
          end
        end
        S_GOT_E0F0: begin
          w_state_nxt = S_IDLE;
          if (w_is_e0 || w_is_f0) w_seq_err = 1'b1;
          else begin
            w_push     = 1'b1;
            w_push_ext = 1'b1;
            w_push_brk = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_seq_err   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tmo     <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_seq_err <= w_seq_err;
      if (rx_valid || (r_state == S_IDLE) || w_timeout) r_tmo <= '0;
      else                                              r_tmo <= r_tmo + 1'b1;
    end
  end

  // Event FIFO. A push into a full FIFO still lands when a pop frees a slot
  // in the same cycle.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_rd    = evt_rd && !w_empty;
  assign w_wr    = w_push && (!w_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {w_push_ext, w_push_brk, rx_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_rd) r_overflow <= 1'b1;
    end
  end

  assign w_head    = r_mem[r_rptr];
  assign evt_code  = w_empty ? '0 : w_head[7:0];
  assign evt_break = w_empty ? 1'b0 : w_head[8];
  assign evt_ext   = w_empty ? 1'b0 : w_head[9];
  assign evt_empty = w_empty;
  assign evt_count = r_count;
  assign overflow  = r_overflow;
  assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic       evt_rd = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_empty;
  logic [3:0] evt_count;
  logic       overflow;
  logic       seq_err;

  int checks = 0;
  int errors = 0;
  int seq_cnt = 0;
  int base;

  ps2_scancode_decoder #(
    .FIFO_DEPTH(8),
    .FIFO_AW(3),
    .TIMEOUT_CYCLES(16000)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .evt_rd(evt_rd), .evt_code(evt_code), .evt_ext(evt_ext),
    .evt_break(evt_break), .evt_empty(evt_empty), .evt_count(evt_count),
    .overflow(overflow), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Count high cycles of seq_err, sampled mid-cycle.
  always @(negedge clk) if (seq_err) seq_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [7:0] code,
                          input logic ext, input logic brk);
    chk({tag, " empty"}, 32'(evt_empty), 32'd0);
    chk({tag, " code"},  32'(evt_code),  32'(code));
    chk({tag, " ext"},   32'(evt_ext),   32'(ext));
    chk({tag, " brk"},   32'(evt_break), 32'(brk));
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    #2;
  endtask

  task automatic pop();
    @(negedge clk); evt_rd = 1'b1;
    @(negedge clk); evt_rd = 1'b0;
    #2;
  endtask

  task automatic err_pulse();
    @(negedge clk); rx_err = 1'b1;
    @(negedge clk); rx_err = 1'b0;
    #2;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " empty"},    32'(evt_empty), 32'd1);
    chk({tag, " count"},    32'(evt_count), 32'd0);
    chk({tag, " code"},     32'(evt_code),  32'd0);
    chk({tag, " ext"},      32'(evt_ext),   32'd0);
    chk({tag, " brk"},      32'(evt_break), 32'd0);
    chk({tag, " overflow"}, 32'(overflow),  32'd0);
    chk({tag, " seq_err"},  32'(seq_err),   32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    chk_reset_state("reset");

    // Single make code, one-cycle latency, then pop.
    send(8'h1C);
    chk_head("make1C", 8'h1C, 1'b0, 1'b0);
    chk("make1C count", 32'(evt_count), 32'd1);
    pop();
    chk("pop empty", 32'(evt_empty), 32'd1);
    chk("pop code", 32'(evt_code), 32'd0);

    // Break, extended make, extended break.
    base = seq_cnt;
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("seq3 count", 32'(evt_count), 32'd3);
    chk("seq3 seq_err", 32'(seq_cnt - base), 32'd0);
    chk_head("ev1", 8'h1C, 1'b0, 1'b1); pop();
    chk_head("ev2", 8'h75, 1'b1, 1'b0); pop();
    chk_head("ev3", 8'h75, 1'b1, 1'b1); pop();
    chk("seq3 drained", 32'(evt_empty), 32'd1);

    // Discards, then an illegal F0 F0.
    send(8'hAA); send(8'hFA); send(8'hEE); send(8'h00);
    chk("discard count", 32'(evt_count), 32'd0);
    chk("discard seq_err", 32'(seq_cnt - base), 32'd0);
    send(8'hF0); send(8'hF0);
    chk("F0F0 pulse now", 32'(seq_err), 32'd1);
    @(negedge clk); #2;
    chk("F0F0 pulses", 32'(seq_cnt - base), 32'd1);
    chk("F0F0 count", 32'(evt_count), 32'd0);
    send(8'h1C);
    chk_head("after F0F0", 8'h1C, 1'b0, 1'b0); pop();

    // Timeout after a lone E0: pulse on the 16000th edge after the byte.
    base = seq_cnt;
    send(8'hE0);
    repeat (15998) @(negedge clk);
    #2;
    chk("tmo early", 32'(seq_cnt - base), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    chk("tmo pulse", 32'(seq_cnt - base), 32'd1);
    repeat (5) @(negedge clk);
    #2;
    chk("tmo once", 32'(seq_cnt - base), 32'd1);
    send(8'h1C);
    chk_head("after tmo", 8'h1C, 1'b0, 1'b0); pop();

    // rx_err mid-sequence vs in IDLE.
    base = seq_cnt;
    send(8'hE0);
    err_pulse();
    chk("rxerr seq", 32'(seq_cnt - base), 32'd1);
    err_pulse();
    @(negedge clk); #2;
    chk("rxerr idle", 32'(seq_cnt - base), 32'd1);
    send(8'h1C);
    chk_head("after rxerr", 8'h1C, 1'b0, 1'b0); pop();

    // Push and pop together when empty: pop ignored.
    @(negedge clk); rx_data = 8'h33; rx_valid = 1'b1; evt_rd = 1'b1;
    @(negedge clk); rx_valid = 1'b0; evt_rd = 1'b0; #2;
    chk("emptyrw count", 32'(evt_count), 32'd1);
    chk_head("emptyrw", 8'h33, 1'b0, 1'b0); pop();

    // Fill, simultaneous push+pop when full, then overflow.
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("full count", 32'(evt_count), 32'd8);
    chk("full ovf", 32'(overflow), 32'd0);
    chk_head("full head", 8'h01, 1'b0, 1'b0);
    @(negedge clk); rx_data = 8'h0A; rx_valid = 1'b1; evt_rd = 1'b1;
    @(negedge clk); rx_valid = 1'b0; evt_rd = 1'b0; #2;
    chk("fullrw count", 32'(evt_count), 32'd8);
    chk("fullrw ovf", 32'(overflow), 32'd0);
    chk_head("fullrw head", 8'h02, 1'b0, 1'b0);
    send(8'h09);
    chk("ovf count", 32'(evt_count), 32'd8);
    chk("ovf flag", 32'(overflow), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      chk_head("drain", 8'(i), 1'b0, 1'b0);
      pop();
    end
    chk_head("drain tail", 8'h0A, 1'b0, 1'b0);
    pop();
    chk("drained", 32'(evt_empty), 32'd1);
    chk("ovf sticky", 32'(overflow), 32'd1);

    // Reset mid-sequence, with an event held and overflow set.
    send(8'h44);
    send(8'hF0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; #2;
    chk_reset_state("midreset");
    send(8'h1C);
    chk_head("after reset", 8'h1C, 1'b0, 1'b0);
    chk("after reset count", 32'(evt_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver and consumes its received-byte stream.
- Decodes set-2 prefixes (E0 extended, F0 break) into single key events, each tagged with an extended flag and a break flag.
- Discards keyboard status/response bytes.
- Buffers decoded events in a first-word-fall-through FIFO read by the host logic. Runs in the 16 MHz system clock domain.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, 2 or more.
FIFO_AW, 3, log2(FIFO_DEPTH).
TIMEOUT_CYCLES, 16000, idle cycles before an incomplete prefix sequence is abandoned (1 ms at 16 MHz).

Ports:
clk  input  1  system clock (16 MHz); all logic on rising edge.
reset  input  1  synchronous, active-high reset.
rx_data  input  8  received byte; valid only while rx_valid=1.
rx_valid  input  1  one-cycle strobe per received byte.
rx_err  input  1  one-cycle strobe on receiver framing/parity error.
evt_rd  input  1  pop head event; ignored when evt_empty=1.
evt_code  output  8  head event scan code; 0 when empty.
evt_ext  output  1  head event had E0 prefix; 0 when empty.
evt_break  output  1  head event is a key release; 0 when empty.
evt_empty  output  1  FIFO empty.
evt_count  output  FIFO_AW+1  number of events held.
overflow  output  1  sticky; an event was lost because the FIFO was full.
seq_err  output  1  one-cycle pulse when a prefix sequence is aborted.

Behaviour:
- Reset values: FSM=IDLE; FIFO empty; evt_empty=1; evt_count=0; evt_code/evt_ext/evt_break=0; overflow=0; seq_err=0; timeout counter=0.
- Reset mid-sequence discards the partial prefix; it takes priority over every other input in the same cycle.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions occur only on cycles with rx_valid=1, except timeout and rx_err.
- Discard bytes in IDLE (no push, stay IDLE): AA, FA, EE, FE, 00, FF, E1.
- Pause (E1) sequences get no special handling.
- IDLE:
  - E0 -> GOT_E0.
  - F0 -> GOT_F0.
  - Discard byte -> IDLE.
  - Any other byte -> push {code, ext=0, brk=0}.
- GOT_E0:
  - F0 -> GOT_E0F0.
  - E0 -> stay.
  - Other -> push {code, 1, 0} -> IDLE.
- GOT_F0:
  - E0 or F0 -> seq_err pulse, byte dropped -> IDLE.
  - Other -> push {code, 0, 1} -> IDLE.
- GOT_E0F0:
  - E0 or F0 -> seq_err pulse, byte dropped -> IDLE.
  - Other -> push {code, 1, 1} -> IDLE.
- Timeout counter:
  - Cleared on every rx_valid and in IDLE.
  - Increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 in a non-IDLE state -> IDLE, seq_err pulse, counter cleared.
- rx_err in any state:
  - Next state IDLE.
  - seq_err pulses only if the state was not IDLE.
  - A coincident rx_valid byte is ignored; rx_err wins.
- Push latency: the push is registered on the edge that samples rx_valid. From that edge, evt_empty=0, the evt_* outputs show the head, and evt_count is updated. Net latency is one cycle from the strobe.
- FIFO ordering is strict FIFO. evt_* always reflect the current head (fall-through).
- evt_rd with evt_empty=0 advances the head at the next edge.
- Full boundary:
  - Push when full without evt_rd: event dropped, overflow<=1; only reset clears it.
  - Push and evt_rd in the same cycle when full: both take effect, count unchanged, no overflow.
- Empty boundary: push and evt_rd in the same cycle when empty: evt_rd ignored, push accepted, count=1.
- Pointers wrap modulo FIFO_DEPTH.
- evt_count ranges 0..FIFO_DEPTH (needs FIFO_AW+1 bits).

Test Plan:
- rx 1C -> one cycle later evt_empty=0, evt_code=1C, ext=0, break=0, count=1; evt_rd -> empty=1, code=00.
- Sequences F0 1C, then E0 75, then E0 F0 75 -> three events in order: {1C,0,1}, {75,1,0}, {75,1,1}; no seq_err.
- rx AA, FA, EE, 00 -> count stays 0, no seq_err; then F0 F0 -> seq_err one pulse, FSM IDLE; then 1C -> {1C,0,0}.
- rx E0, idle 16000 cycles -> seq_err pulse exactly once; then 1C -> {1C,0,0}. Repeat with rx_err after E0 -> seq_err; rx_err in IDLE -> no pulse.
- Nine make codes 01..09, no reads -> count=8, overflow=1, code 09 lost; reads return 01..08. With FIFO full, push 0A plus evt_rd in the same cycle -> count stays 8, tail=0A.
- rx F0, assert reset one cycle, rx 1C -> {1C,0,0}; after reset, all outputs at their reset values.
